// File: rtl/seq_gf_inverter.sv
// Multi-cycle GF(2^8) inverter: byte_out = byte_in^254 mod (x^8 + POLY), via 7 square-and-multiply steps.
// Optional result self-check output err is enabled with `define SEQ_GF_INVERTER_SELFCHECK_EN.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for an operand, in_ready high
// S_CALC | square-and-multiply iterations, cnt counts 0..ITER-1
// S_DONE | result presented on byte_out, waiting for out_ready
module seq_gf_inverter #(
   parameter logic [7:0] POLY = 8'h1B,
   parameter int         ITER = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] byte_in,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] byte_out,
   output logic       busy
`ifdef SEQ_GF_INVERTER_SELFCHECK_EN
   ,
   output logic       err
`endif
);

   generate
      if (ITER != 7) begin : g_bad_iter
         $error("seq_gf_inverter: ITER must be 7 to compute x^254");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ POLY) : (aa << 1);
      end
      return p;
   endfunction

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_acc;
   logic [7:0] r_sq;
   logic [7:0] r_byte_out;
   logic [2:0] r_cnt;
   logic [7:0] w_s2;
   logic [7:0] w_acc_nxt;
   logic       w_last;
   logic       w_accept;
   logic       w_deliver;

   assign w_s2      = gf_mul(r_sq, r_sq);
   assign w_acc_nxt = gf_mul(r_acc, w_s2);
   assign w_last    = (r_cnt == 3'(ITER - 1));
   assign w_accept  = (r_state == S_IDLE) && in_valid;
   assign w_deliver = (r_state == S_DONE) && out_ready;
   assign byte_out  = r_byte_out;

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = S_CALC;
         end
         S_CALC: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_acc      <= 8'h01;
         r_sq       <= 8'h00;
         r_cnt      <= 3'd0;
         r_byte_out <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_sq  <= byte_in;
            r_acc <= 8'h01;
            r_cnt <= 3'd0;
         end else if (r_state == S_CALC) begin
            r_sq  <= w_s2;
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 3'd1;
            if (w_last) r_byte_out <= w_acc_nxt;
         end
      end
   end

`ifdef SEQ_GF_INVERTER_SELFCHECK_EN
   logic [7:0] r_operand;
   logic [7:0] w_prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_operand <= 8'h00;
      else if (w_accept) r_operand <= byte_in;
   end

   // Zero has no inverse, so its only valid result is zero itself.
   assign w_prod = gf_mul(r_byte_out, r_operand);
   assign err    = (r_state == S_DONE) &&
                   ((r_operand != 8'h00) ? (w_prod != 8'h01) : (r_byte_out != 8'h00));
`else
   logic w_unused;
   assign w_unused = w_deliver;
`endif

endmodule

// File: tb/tb_seq_gf_inverter.sv
// Self-checking bench for seq_gf_inverter: directed vectors, backpressure, reset abort,
// exhaustive sweep and random stalls, all against a polynomial-arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_gf_inverter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] byte_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] byte_out;
   logic       busy;
`ifdef SEQ_GF_INVERTER_SELFCHECK_EN
   logic       err;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [7:0] inv_tab [256];

   seq_gf_inverter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .byte_in   (byte_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .byte_out  (byte_out),
      .busy      (busy)
`ifdef SEQ_GF_INVERTER_SELFCHECK_EN
      ,
      .err       (err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 14; i >= 8; i--)
         if (p[i]) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] ref_inv(input logic [7:0] x);
      if (x == 8'h00) return 8'h00;
      for (int y = 1; y < 256; y++)
         if (ref_mul(x, 8'(y)) == 8'h01) return 8'(y);
      return 8'hEE;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept an operand, wait for the result, check it, then hand it off with out_ready=1.
   task automatic do_op(input logic [7:0] op, input logic [7:0] exp, input string tag);
      int lat;
      check_eq({tag, "_in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      byte_in  = op;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      byte_in  = $urandom();
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (lat == 3) check_eq({tag, "_busy_calc"}, busy, 1'b1);
         tick();
         lat++;
      end
      check_eq({tag, "_latency"}, lat, 7);
      check_eq({tag, "_result"}, byte_out, exp);
`ifdef SEQ_GF_INVERTER_SELFCHECK_EN
      check_eq({tag, "_err"}, err, 1'b0);
`endif
      tick();
      check_eq({tag, "_ov_drop"}, out_valid, 1'b0);
      check_eq({tag, "_ready_back"}, in_ready, 1'b1);
   endtask

   initial begin
      logic [7:0] dir_op  [5];
      logic [7:0] dir_exp [5];
      int start_cyc;
      int extra;
      int stalls;
      logic [7:0] op;
      logic [7:0] held;

      for (int i = 0; i < 256; i++) inv_tab[i] = ref_inv(8'(i));

      rst_n = 1'b0; in_valid = 1'b0; byte_in = 8'h00; out_ready = 1'b0;
      tick(); tick();
      check_eq("rst_in_ready", in_ready, 1'b1);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_byte_out", byte_out, 8'h00);
      check_eq("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      tick();

      dir_op  = '{8'h53, 8'h00, 8'h01, 8'h02, 8'hFF};
      dir_exp = '{8'hCA, 8'h00, 8'h01, 8'h8D, 8'h1C};
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("model_%02h", dir_op[i]), inv_tab[dir_op[i]], dir_exp[i]);
         do_op(dir_op[i], dir_exp[i], $sformatf("dir_%02h", dir_op[i]));
      end
      check_eq("idle_keeps_result", byte_out, 8'h1C);

      // Backpressure: hold the 0x53 result for 5 cycles with a spurious operand in between.
      out_ready = 1'b0;
      in_valid = 1'b1; byte_in = 8'h53;
      tick();
      in_valid = 1'b0;
      extra = 0;
      while (!out_valid && extra < 20) begin tick(); extra++; end
      check_eq("bp_latency", extra, 7);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i == 2);
         byte_in  = 8'h02;
         tick();
         check_eq("bp_out_valid", out_valid, 1'b1);
         check_eq("bp_byte_out", byte_out, 8'hCA);
         check_eq("bp_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check_eq("bp_drop", out_valid, 1'b0);
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid) extra++;
      end
      check_eq("bp_single_result", extra, 0);
      check_eq("bp_result_kept", byte_out, 8'hCA);

      // Reset during CALC with cnt=3 discards the partial result.
      in_valid = 1'b1; byte_in = 8'h53;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check_eq("abort_out_valid", out_valid, 1'b0);
      check_eq("abort_byte_out", byte_out, 8'h00);
      check_eq("abort_in_ready", in_ready, 1'b1);
      check_eq("abort_busy", busy, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      do_op(8'h02, 8'h8D, "post_abort");

      // Exhaustive back-to-back sweep.
      start_cyc = cyc;
      for (int i = 0; i < 256; i++) do_op(8'(i), inv_tab[i], $sformatf("sweep_%02h", i));
      check_eq("sweep_cycles", cyc - start_cyc, 256 * 9);

      // Random operands with random consumer stalls.
      for (int n = 0; n < 30; n++) begin
         op = 8'($urandom());
         out_ready = 1'b0;
         in_valid = 1'b1; byte_in = op;
         tick();
         in_valid = 1'b0;
         extra = 0;
         while (!out_valid && extra < 20) begin tick(); extra++; end
         check_eq("rnd_latency", extra, 7);
         check_eq($sformatf("rnd_%02h", op), byte_out, inv_tab[op]);
         held = byte_out;
         stalls = 0;
         out_ready = 1'b0;
         while (!out_ready) begin
            out_ready = (stalls >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            byte_in = 8'($urandom());
            tick();
            if (!out_ready) begin
               check_eq("rnd_hold_valid", out_valid, 1'b1);
               check_eq("rnd_hold_data", byte_out, held);
            end
            stalls++;
         end
         in_valid = 1'b0;
         check_eq("rnd_drop", out_valid, 1'b0);
      end

`ifdef SEQ_GF_INVERTER_SELFCHECK_EN
      out_ready = 1'b0;
      in_valid = 1'b1; byte_in = 8'h53;
      tick();
      in_valid = 1'b0;
      extra = 0;
      while (!out_valid && extra < 20) begin tick(); extra++; end
      check_eq("sc_clean_err", err, 1'b0);
      force dut.r_byte_out = 8'h00;
      #1;
      check_eq("sc_forced_err", err, 1'b1);
      release dut.r_byte_out;
      out_ready = 1'b1;
      tick();
      check_eq("sc_err_clear", err, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule
